alarm_sequencer: RTL

- Owns the alarm lifecycle after the time/alarm registers: arm, ring, snooze, auto-timeout, dismiss.
- Sits beside the master controller. Consumes the running time, alarm time, enable switch and debounced snooze/dismiss pulses.
- Drives the buzzer and status LEDs.
- All timing is derived from an external 1 Hz strobe; there are no internal clock dividers.

---
 rtl/alarm_pkg.sv | 17 +
 rtl/tick_down_counter.sv | 27 ++
 rtl/alarm_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm sequencer: state codes, time base constants
// and the BCD HH:MM time width.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_SNOOZE  = 3'd3,
    ST_DONE    = 3'd4
  } alarm_state_e;

  localparam int unsigned SECONDS_PER_MIN = 60;
  localparam int unsigned ESCALATE_S      = 10;
  localparam int unsigned TIME_W          = 16;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down-counter stepped by a strobe; saturates at zero and flags the
// strobe that takes it from 1 to 0.
module tick_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             expire
);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = tick & (count == WIDTH'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm lifecycle FSM: arm, ring, snooze, auto-timeout, dismiss; all timing from
// the external 1 Hz strobe. Optional macro ALARM_ESCALATE_EN holds the buzzer on
// continuously after ESCALATE_S seconds of ringing.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN     = 9,
  parameter int unsigned MAX_SNOOZE     = 3,
  parameter int unsigned RING_TIMEOUT_S = 300
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Sec_Tick,
  input  logic [TIME_W-1:0] i_Time,
  input  logic [TIME_W-1:0] i_Alarm_Time,
  input  logic              i_Alarm_Enable,
  input  logic              i_Snooze,
  input  logic              i_Dismiss,
  output logic              o_Ringing,
  output logic              o_Snoozing,
  output logic              o_Buzzer,
  output logic [3:0]        o_Snooze_Count,
  output logic [2:0]        o_State
);

  localparam int unsigned SNZ_W  = $clog2(SNOOZE_MIN * SECONDS_PER_MIN + 1);
  localparam int unsigned RING_W = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN * SECONDS_PER_MIN);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_TIMEOUT_S);
  localparam logic [3:0]        SNZ_LIMIT = 4'(MAX_SNOOZE);

  alarm_state_e state_q, state_d;
  logic match, clr, ring_load, snz_load, snz_accept;
  logic ring_expire, snz_expire, buzz_toggle;
  logic [RING_W-1:0] ring_cnt;
  logic [SNZ_W-1:0]  snz_cnt;

  assign match = (i_Time == i_Alarm_Time);

  tick_down_counter #(.WIDTH(RING_W)) u_ring_cnt (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .load       (ring_load | clr),
    .load_value (clr ? '0 : RING_LOAD),
    .tick       (i_Sec_Tick & (state_q == ST_RINGING)),
    .count      (ring_cnt),
    .expire     (ring_expire)
  );

  tick_down_counter #(.WIDTH(SNZ_W)) u_snz_cnt (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .load       (snz_load | clr),
    .load_value (clr ? '0 : SNZ_LOAD),
    .tick       (i_Sec_Tick & (state_q == ST_SNOOZE)),
    .count      (snz_cnt),
    .expire     (snz_expire)
  );

  always_comb begin
    state_d    = state_q;
    clr        = 1'b0;
    ring_load  = 1'b0;
    snz_load   = 1'b0;
    snz_accept = 1'b0;
    if (!i_Alarm_Enable) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_ARMED;
        ST_ARMED: begin
          if (match) begin
            state_d   = ST_RINGING;
            ring_load = 1'b1;
          end
        end
        ST_RINGING: begin
          if (i_Dismiss) begin
            state_d = ST_DONE;
          end else if (i_Snooze && (o_Snooze_Count < SNZ_LIMIT)) begin
            state_d    = ST_SNOOZE;
            snz_load   = 1'b1;
            snz_accept = 1'b1;
          end else if (ring_expire || (ring_cnt == '0)) begin
            // an emptied counter without expiry cannot hold the state forever
            state_d = ST_DONE;
          end
        end
        ST_SNOOZE: begin
          if (i_Dismiss) begin
            state_d = ST_DONE;
          end else if (snz_expire || (snz_cnt == '0)) begin
            state_d   = ST_RINGING;
            ring_load = 1'b1;
          end
        end
        ST_DONE:  if (!match) state_d = ST_ARMED;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

`ifdef ALARM_ESCALATE_EN
  localparam int unsigned ESC_W = $clog2(ESCALATE_S + 1);
  logic [ESC_W-1:0] esc_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      esc_q <= '0;
    end else if (state_q != ST_RINGING) begin
      esc_q <= '0;
    end else if (i_Sec_Tick && (esc_q != ESC_W'(ESCALATE_S))) begin
      esc_q <= esc_q + ESC_W'(1);
    end
  end

  assign buzz_toggle = (esc_q >= ESC_W'(ESCALATE_S - 1)) ? 1'b1 : ~o_Buzzer;
`else
  assign buzz_toggle = ~o_Buzzer;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q        <= ST_IDLE;
      o_Ringing      <= 1'b0;
      o_Snoozing     <= 1'b0;
      o_Buzzer       <= 1'b0;
      o_Snooze_Count <= '0;
    end else begin
      state_q    <= state_d;
      o_Ringing  <= (state_d == ST_RINGING);
      o_Snoozing <= (state_d == ST_SNOOZE);
      if (state_d != ST_RINGING) begin
        o_Buzzer <= 1'b0;
      end else if (state_q != ST_RINGING) begin
        o_Buzzer <= 1'b1;
      end else if (i_Sec_Tick) begin
        o_Buzzer <= buzz_toggle;
      end
      if (clr || (state_d == ST_DONE)) begin
        o_Snooze_Count <= '0;
      end else if (snz_accept) begin
        o_Snooze_Count <= o_Snooze_Count + 4'd1;
      end
    end
  end

  assign o_State = state_q;

endmodule
